uart_rx_dma: RTL

Sequencer that drains the UART receive peripheral into system memory without CPU involvement. It polls the UART status register, reads received bytes, packs four bytes little-endian into a 32-bit word and writes each word to memory. It stops after a programmed word count, then raises a one-cycle interrupt. It sits between the CPU register bus, the UART RX bus slave and one memory-bus master port.

---
 rtl/uart_rx_dma.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_dma.sv
// UART receive-to-memory sequencer: polls the UART, packs four bytes little-endian
// into a word, writes each word to memory and interrupts after COUNT words.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | wait for a CTRL start
// POLL    | read UART status until i_uart_ready
// GAP_P   | request low one cycle; branch on the latched empty flag
// WAIT    | FIFO was empty; count PRESCALE_POLL cycles before the next poll
// READ    | read one data byte into lane idx
// GAP_R   | request low one cycle; next byte or write the packed word
// WRITE   | memory write until i_bus_ready; advance pointer and progress
// DONE    | clear busy, set done, finish the interrupt pulse
module uart_rx_dma #(
  parameter int PRESCALE_POLL = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [1:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt,
  output logic        o_uart_request,
  output logic [1:0]  o_uart_address,
  input  logic [31:0] i_uart_rdata,
  input  logic        i_uart_ready,
  output logic        o_bus_request,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready
);

  localparam int CW = (PRESCALE_POLL > 1) ? $clog2(PRESCALE_POLL) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(PRESCALE_POLL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_GAP_P, S_WAIT, S_READ, S_GAP_R, S_WRITE, S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   base_reg;
  logic [15:0]   count_reg;
  logic [15:0]   progress;
  logic          busy;
  logic          done;
  logic [31:0]   addr_ptr;
  logic [1:0]    idx;
  logic [31:0]   word_buf;
  logic          empty_flag;
  logic [CW-1:0] wait_cnt;

  logic wr_en;
  logic start;
  logic unused_rdata;

  assign wr_en        = i_request && i_rw && !busy;
  assign start        = wr_en && (i_address == 2'd2) && i_wdata[0];
  assign o_ready      = i_request;
  assign unused_rdata = &{1'b0, i_uart_rdata[31:8]};

  always_comb begin
    o_rdata = 32'd0;
    case (i_address)
      2'd0: o_rdata = base_reg;
      2'd1: o_rdata = {16'd0, count_reg};
      2'd2: o_rdata = {29'd0, done, busy, 1'b0};
      2'd3: o_rdata = {16'd0, progress};
      default: o_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= S_IDLE;
      base_reg       <= 32'd0;
      count_reg      <= 16'd0;
      progress       <= 16'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      addr_ptr       <= 32'd0;
      idx            <= 2'd0;
      word_buf       <= 32'd0;
      empty_flag     <= 1'b0;
      wait_cnt       <= '0;
      o_interrupt    <= 1'b0;
      o_uart_request <= 1'b0;
      o_uart_address <= 2'd0;
      o_bus_request  <= 1'b0;
      o_bus_address  <= 32'd0;
      o_bus_wdata    <= 32'd0;
    end else begin
      if (wr_en && i_address == 2'd0) base_reg <= {i_wdata[31:2], 2'b00};
      if (wr_en && i_address == 2'd1) count_reg <= i_wdata[15:0];
      o_interrupt <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            progress <= 16'd0;
            addr_ptr <= base_reg;
            idx      <= 2'd0;
            if (count_reg == 16'd0) begin
              state <= S_DONE;
            end else begin
              o_uart_request <= 1'b1;
              o_uart_address <= 2'd1;
              state          <= S_POLL;
            end
          end
        end
        S_POLL: begin
          if (i_uart_ready) begin
            o_uart_request <= 1'b0;
            empty_flag     <= i_uart_rdata[1];
            state          <= S_GAP_P;
          end
        end
        S_GAP_P: begin
          if (empty_flag) begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_WAIT;
          end else begin
            o_uart_request <= 1'b1;
            o_uart_address <= 2'd0;
            state          <= S_READ;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            o_uart_request <= 1'b1;
            o_uart_address <= 2'd1;
            state          <= S_POLL;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_READ: begin
          if (i_uart_ready) begin
            o_uart_request               <= 1'b0;
            word_buf[{idx, 3'b000} +: 8] <= i_uart_rdata[7:0];
            state                        <= S_GAP_R;
          end
        end
        S_GAP_R: begin
          if (idx == 2'd3) begin
            idx           <= 2'd0;
            o_bus_request <= 1'b1;
            o_bus_address <= addr_ptr;
            o_bus_wdata   <= word_buf;
            state         <= S_WRITE;
          end else begin
            idx            <= idx + 2'd1;
            o_uart_request <= 1'b1;
            o_uart_address <= 2'd1;
            state          <= S_POLL;
          end
        end
        S_WRITE: begin
          if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            addr_ptr      <= addr_ptr + 32'd4;
            progress      <= progress + 16'd1;
            // Interrupt goes out alongside the last write's completion.
            if (progress + 16'd1 == count_reg) begin
              o_interrupt <= 1'b1;
              state       <= S_DONE;
            end else begin
              o_uart_request <= 1'b1;
              o_uart_address <= 2'd1;
              state          <= S_POLL;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          // A zero-length transfer has not pulsed yet, so it pulses on leaving DONE.
          o_interrupt <= (count_reg == 16'd0);
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
